dmem_responder: RTL

Memory-side responder for the datapath's data-memory request interface. It accepts level-held read/write requests (dmemREN/dmemWEN), waits a configurable number of wait states, and returns a single-cycle dhit with read data. It is backed by a small word-addressed local store. It sits between the pipeline's request unit and the rest of the memory system, and serves as a fixed-latency stand-in for a data cache in bring-up and latency-sensitivity testing.

---
 rtl/cpu_types_pkg.sv | 6 +
 rtl/dmem_responder_pkg.sv | 16 +
 rtl/dmem_word_array.sv | 40 ++++
 rtl/dmem_responder.sv | 118 +++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Datapath-wide scalar types shared across the CPU and its memory-side blocks.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

endpackage : cpu_types_pkg

// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the fixed-latency data-memory responder.
package dmem_responder_pkg;

    typedef cpu_types_pkg::word_t word_t;

    localparam int LAT_W = 4;

    typedef logic [LAT_W-1:0] wcnt_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HIT
    } dmem_state_t;

endpackage : dmem_responder_pkg

// File: rtl/dmem_word_array.sv
// DEPTH x 32 local store: one write port, one registered read port, async clear to zero.
module dmem_word_array
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic             re,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);

    word_t mem [DEPTH];

    // NOTE: the store is cleared on reset, so it maps to flops rather than an SRAM macro; fine at this depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            // NOTE: non-blocking so every reader on this edge sees the pre-edge contents.
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule : dmem_word_array

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: LAT wait states, then a one-cycle dhit.
// Define DMEM_STATS_EN to add the rd_count/wr_count completion counters.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int LAT   = 2,
    parameter int DEPTH = 64
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        dhit,
`ifdef DMEM_STATS_EN
    output logic [31:0] rd_count,
    output logic [31:0] wr_count,
`endif
    output logic [31:0] dmemload
);

    localparam int    IDX_W     = $clog2(DEPTH);
    localparam wcnt_t WCNT_INIT = (LAT > 0) ? LAT_W'(LAT - 1) : '0;

    dmem_state_t      state, state_next;
    wcnt_t            wcnt, wcnt_next;
    logic             req;
    logic             commit;
    logic             commit_wr;
    logic             commit_rd;
    logic [IDX_W-1:0] idx;
    logic             unused_addr_bits;

    // Op and index are taken from the live inputs on the commit edge, so nothing
    // sampled at acceptance needs to be kept.
    assign req              = dmemREN | dmemWEN;
    assign idx              = dmemaddr[IDX_W+1:2];
    assign unused_addr_bits = ^{dmemaddr[31:IDX_W+2], dmemaddr[1:0]};

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            wcnt  <= '0;
        end else begin
            state <= state_next;
            wcnt  <= wcnt_next;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_next = state;
        wcnt_next  = wcnt;
        commit     = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    if (LAT == 0) begin
                        state_next = HIT;
                        commit     = 1'b1;
                    end else begin
                        state_next = WAIT;
                        wcnt_next  = WCNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_next = IDLE;
                end else if (wcnt == '0) begin
                    state_next = HIT;
                    commit     = 1'b1;
                end else begin
                    wcnt_next = wcnt - LAT_W'(1);
                end
            end
            HIT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A commit implies a live request; write wins when both lines are high.
    assign commit_wr = commit & dmemWEN;
    assign commit_rd = commit & ~dmemWEN;
    assign dhit      = (state == HIT);

    dmem_word_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_word_array (
        .clk   (CLK),
        .rst_n (nRST),
        .we    (commit_wr),
        .waddr (idx),
        .wdata (dmemstore),
        .re    (commit_rd),
        .raddr (idx),
        .rdata (dmemload)
    );

`ifdef DMEM_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (commit_rd) rd_count <= rd_count + 32'd1;
            if (commit_wr) wr_count <= wr_count + 32'd1;
        end
    end
`endif

endmodule : dmem_responder
